// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - RX FIFO write port and status pulses of the UART receiver.
// UART_RX_PARITY_EN adds the parity_err pulse.
interface uart_receiver_if #(
    parameter int DATA_BITS = 8
);
    logic                 rf_full;
    logic                 rf_wrreq;
    logic [DATA_BITS-1:0] rf_data;
    logic                 frame_err;
    logic                 overrun;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;
`endif

    modport master (
        input  rf_full,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output rf_wrreq,
        output rf_data,
        output frame_err,
        output overrun
    );

    modport slave (
        output rf_full,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  rf_wrreq,
        input  rf_data,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 16x-oversampled UART receive engine feeding the RX FIFO.
// UART_RX_PARITY_EN builds in an even-parity bit between data and stop.
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic            uart_clk,
    input  logic            rst,
    input  logic            uart_rxd_i,
    uart_receiver_if.master rf
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] IDX_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 wrreq_q, wrreq_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 rxd_meta_q, rxd_s_q, rxd_prev_q;
    logic                 fall;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q, par_bit_d;
    logic                 perr_q, perr_d;
`endif

    // Synchronizer idles high so reset never looks like a start edge.
    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= uart_rxd_i;
            rxd_s_q    <= rxd_meta_q;
            rxd_prev_q <= rxd_s_q;
        end
    end

    assign fall = rxd_prev_q & ~rxd_s_q;

    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            wrreq_q   <= 1'b0;
            data_q    <= '0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            wrreq_q   <= wrreq_d;
            data_q    <= data_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
            perr_q    <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_END) ? '0 : cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        wrreq_d   = 1'b0;
        data_d    = data_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d = par_bit_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxd_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_END) begin
                    shift_d   = {rxd_s_q, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx_q == IDX_LAST) state_d = S_PARITY;
`else
                    if (bit_idx_q == IDX_LAST) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_END) begin
                    par_bit_d = rxd_s_q;
                    state_d   = S_STOP;
                end
            end
`endif
            // Leave at mid-stop so a back-to-back start edge is not missed.
            S_STOP: begin
                if (cnt_q == CNT_END) begin
                    state_d = S_IDLE;
                    if (!rxd_s_q) begin
                        ferr_d = 1'b1;
                    end else if (rf.rf_full) begin
                        ovr_d = 1'b1;
                    end else begin
                        wrreq_d = 1'b1;
                        data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^{shift_q, par_bit_q};
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rf.rf_wrreq  = wrreq_q;
    assign rf.rf_data   = data_q;
    assign rf.frame_err = ferr_q;
    assign rf.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign rf.parity_err = perr_q;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver against a frame-level model.
// UART_RX_PARITY_EN switches frames and expectations to the parity variant.
module tb_uart_receiver;
    localparam int OS = 16;
    localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int LAT       = OS / 2 + OS * (DB + 1) + 1 + (PAR_EN ? OS : 0);
    localparam int FRAME_CYC = OS * (DB + 2) + (PAR_EN ? OS : 0);
    localparam logic [1:0] K_WR = 2'd0, K_FE = 2'd1, K_OV = 2'd2;

    typedef struct packed {
        int          cyc;
        logic [1:0]  kind;
        logic [DB-1:0] data;
        logic        perr;
    } ev_t;
    typedef ev_t evq_t[$];

    typedef struct packed {
        logic [DB-1:0] d;
        logic        stop;
        logic        par;
        logic        full;
        int          fall;
    } sent_t;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   rule_viol = 0;
    bit   prev_pulse = 1'b0;
    ev_t  evq[$];
    sent_t sentq[$];
    evq_t exp;

    uart_receiver_if #(.DATA_BITS(DB)) rf_if ();

    uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .uart_clk  (clk),
        .rst       (rst),
        .uart_rxd_i(rxd),
        .rf        (rf_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int  n;
        ev_t e;
        n = int'(rf_if.rf_wrreq) + int'(rf_if.frame_err) + int'(rf_if.overrun);
`ifdef UART_RX_PARITY_EN
        if (rf_if.parity_err && !rf_if.rf_wrreq) rule_viol++;
`endif
        if (n > 1 || (n > 0 && prev_pulse)) rule_viol++;
        prev_pulse = (n > 0);
        if (n > 0) begin
            e.cyc  = cyc;
            e.kind = rf_if.rf_wrreq ? K_WR : (rf_if.frame_err ? K_FE : K_OV);
            e.data = rf_if.rf_wrreq ? rf_if.rf_data : '0;
`ifdef UART_RX_PARITY_EN
            e.perr = rf_if.rf_wrreq & rf_if.parity_err;
`else
            e.perr = 1'b0;
`endif
            evq.push_back(e);
        end
    end

    // Frame-level expectation: one outcome per frame, at a fixed delay from its start edge.
    function automatic evq_t model_events();
        evq_t q;
        ev_t  e;
        foreach (sentq[i]) begin
            e.cyc  = sentq[i].fall + 2 + LAT;
            e.data = '0;
            e.perr = 1'b0;
            if (!sentq[i].stop) e.kind = K_FE;
            else if (sentq[i].full) e.kind = K_OV;
            else begin
                e.kind = K_WR;
                e.data = sentq[i].d;
                e.perr = PAR_EN ? (^sentq[i].d ^ sentq[i].par) : 1'b0;
            end
            q.push_back(e);
        end
        return q;
    endfunction

    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b, input logic par_b);
        sent_t s;
        s.d = d; s.stop = stop_b; s.par = par_b; s.full = rf_if.rf_full; s.fall = cyc;
        sentq.push_back(s);
        rxd = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            rxd = d[i];
            repeat (OS) @(negedge clk);
        end
        if (PAR_EN) begin
            rxd = par_b;
            repeat (OS) @(negedge clk);
        end
        rxd = stop_b;
        repeat (OS) @(negedge clk);
    endtask

    task automatic start_test();
        evq.delete();
        sentq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; rxd = 1'b1; rf_if.rf_full = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rf_if.rf_wrreq !== 1'b0) begin failures++; $display("FAIL reset_wrreq: got %b want 0", rf_if.rf_wrreq); end
        checks++; if (rf_if.rf_data !== '0) begin failures++; $display("FAIL reset_data: got %h want 00", rf_if.rf_data); end
        checks++; if (rf_if.frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b want 0", rf_if.frame_err); end
        checks++; if (rf_if.overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b want 0", rf_if.overrun); end
        rst = 1'b0;
        repeat (OS) @(negedge clk);
    endtask

    task automatic test_basic();
        start_test();
        send_frame(8'h55, 1'b1, 1'b0);
        repeat (OS) @(negedge clk);
        exp = model_events();
        checks++; if (evq.size() !== exp.size()) begin failures++; $display("FAIL basic_count: got %0d want %0d", evq.size(), exp.size()); end
        foreach (exp[i]) if (i < evq.size()) begin
            checks++;
            if (evq[i] !== exp[i]) begin failures++; $display("FAIL basic_ev%0d: got cyc=%0d kind=%0d data=%h perr=%b want cyc=%0d kind=%0d data=%h perr=%b", i, evq[i].cyc, evq[i].kind, evq[i].data, evq[i].perr, exp[i].cyc, exp[i].kind, exp[i].data, exp[i].perr); end
        end
        if (evq.size() > 0) begin
            checks++;
            if (evq[0].cyc - sentq[0].fall - 2 !== LAT) begin failures++; $display("FAIL basic_latency: got %0d want %0d", evq[0].cyc - sentq[0].fall - 2, LAT); end
        end
    endtask

    task automatic test_back_to_back();
        start_test();
        send_frame(8'hA5, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (OS) @(negedge clk);
        exp = model_events();
        checks++; if (evq.size() !== exp.size()) begin failures++; $display("FAIL b2b_count: got %0d want %0d", evq.size(), exp.size()); end
        foreach (exp[i]) if (i < evq.size()) begin
            checks++;
            if (evq[i] !== exp[i]) begin failures++; $display("FAIL b2b_ev%0d: got cyc=%0d kind=%0d data=%h want cyc=%0d kind=%0d data=%h", i, evq[i].cyc, evq[i].kind, evq[i].data, exp[i].cyc, exp[i].kind, exp[i].data); end
        end
        if (evq.size() == 2) begin
            checks++;
            if (evq[1].cyc - evq[0].cyc !== FRAME_CYC) begin failures++; $display("FAIL b2b_spacing: got %0d want %0d", evq[1].cyc - evq[0].cyc, FRAME_CYC); end
        end
    endtask

    task automatic test_glitch();
        start_test();
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (3 * OS) @(negedge clk);
        checks++; if (evq.size() !== 0) begin failures++; $display("FAIL glitch_quiet: got %0d pulses want 0", evq.size()); end
        send_frame(8'h0F, 1'b1, 1'b1);
        repeat (OS) @(negedge clk);
        exp = model_events();
        checks++; if (evq.size() !== exp.size()) begin failures++; $display("FAIL glitch_count: got %0d want %0d", evq.size(), exp.size()); end
        foreach (exp[i]) if (i < evq.size()) begin
            checks++;
            if (evq[i] !== exp[i]) begin failures++; $display("FAIL glitch_ev%0d: got cyc=%0d kind=%0d data=%h want cyc=%0d kind=%0d data=%h", i, evq[i].cyc, evq[i].kind, evq[i].data, exp[i].cyc, exp[i].kind, exp[i].data); end
        end
    endtask

    task automatic test_frame_err_break();
        start_test();
        send_frame(8'h96, 1'b1, 1'b0);
        send_frame(8'h81, 1'b0, 1'b0);
        repeat (40 * OS) @(negedge clk);
        exp = model_events();
        checks++; if (evq.size() !== exp.size()) begin failures++; $display("FAIL break_count: got %0d want %0d", evq.size(), exp.size()); end
        foreach (exp[i]) if (i < evq.size()) begin
            checks++;
            if (evq[i] !== exp[i]) begin failures++; $display("FAIL break_ev%0d: got cyc=%0d kind=%0d data=%h want cyc=%0d kind=%0d data=%h", i, evq[i].cyc, evq[i].kind, evq[i].data, exp[i].cyc, exp[i].kind, exp[i].data); end
        end
        checks++; if (rf_if.rf_data !== 8'h96) begin failures++; $display("FAIL break_data_hold: got %h want 96", rf_if.rf_data); end
        rxd = 1'b1;
        repeat (2 * OS) @(negedge clk);
    endtask

    task automatic test_overrun();
        start_test();
        rf_if.rf_full = 1'b1;
        send_frame(8'hC3, 1'b1, 1'b0);
        rf_if.rf_full = 1'b0;
        repeat (OS) @(negedge clk);
        exp = model_events();
        checks++; if (evq.size() !== exp.size()) begin failures++; $display("FAIL ovr_count: got %0d want %0d", evq.size(), exp.size()); end
        foreach (exp[i]) if (i < evq.size()) begin
            checks++;
            if (evq[i] !== exp[i]) begin failures++; $display("FAIL ovr_ev%0d: got cyc=%0d kind=%0d data=%h want cyc=%0d kind=%0d data=%h", i, evq[i].cyc, evq[i].kind, evq[i].data, exp[i].cyc, exp[i].kind, exp[i].data); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        start_test();
        d = 8'h7E;
        rxd = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i];
            repeat (OS) @(negedge clk);
        end
        rxd = d[4];
        repeat (OS / 2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (rf_if.rf_data !== '0) begin failures++; $display("FAIL rstmid_data: got %h want 00", rf_if.rf_data); end
        checks++; if ({rf_if.rf_wrreq, rf_if.frame_err, rf_if.overrun} !== 3'b000) begin failures++; $display("FAIL rstmid_pulses: got %b want 000", {rf_if.rf_wrreq, rf_if.frame_err, rf_if.overrun}); end
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2 * OS) @(negedge clk);
        send_frame(8'h7E, 1'b1, 1'b0);
        repeat (OS) @(negedge clk);
        exp = model_events();
        checks++; if (evq.size() !== exp.size()) begin failures++; $display("FAIL rstmid_count: got %0d want %0d", evq.size(), exp.size()); end
        foreach (exp[i]) if (i < evq.size()) begin
            checks++;
            if (evq[i] !== exp[i]) begin failures++; $display("FAIL rstmid_ev%0d: got cyc=%0d kind=%0d data=%h want cyc=%0d kind=%0d data=%h", i, evq[i].cyc, evq[i].kind, evq[i].data, exp[i].cyc, exp[i].kind, exp[i].data); end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        start_test();
        send_frame(8'h03, 1'b1, 1'b1);
        send_frame(8'h03, 1'b1, 1'b0);
        repeat (OS) @(negedge clk);
        exp = model_events();
        checks++; if (evq.size() !== exp.size()) begin failures++; $display("FAIL par_count: got %0d want %0d", evq.size(), exp.size()); end
        foreach (exp[i]) if (i < evq.size()) begin
            checks++;
            if (evq[i] !== exp[i]) begin failures++; $display("FAIL par_ev%0d: got cyc=%0d data=%h perr=%b want cyc=%0d data=%h perr=%b", i, evq[i].cyc, evq[i].data, evq[i].perr, exp[i].cyc, exp[i].data, exp[i].perr); end
        end
        if (evq.size() > 0) begin
            checks++;
            if (evq[0].cyc - sentq[0].fall - 2 !== 169) begin failures++; $display("FAIL par_latency: got %0d want 169", evq[0].cyc - sentq[0].fall - 2); end
        end
    endtask
`endif

    task automatic test_random();
        int gap;
        logic stop_b;
        start_test();
        for (int k = 0; k < 10; k++) begin
            stop_b = ($urandom_range(0, 4) != 0);
            rf_if.rf_full = ($urandom_range(0, 3) == 0);
            send_frame(DB'($urandom), stop_b, 1'($urandom));
            gap = $urandom_range(0, 2);
            if (!stop_b && gap == 0) gap = 1;
            rxd = 1'b1;
            repeat (gap * OS) @(negedge clk);
        end
        rf_if.rf_full = 1'b0;
        repeat (OS) @(negedge clk);
        exp = model_events();
        checks++; if (evq.size() !== exp.size()) begin failures++; $display("FAIL rand_count: got %0d want %0d", evq.size(), exp.size()); end
        foreach (exp[i]) if (i < evq.size()) begin
            checks++;
            if (evq[i] !== exp[i]) begin failures++; $display("FAIL rand_ev%0d: got cyc=%0d kind=%0d data=%h perr=%b want cyc=%0d kind=%0d data=%h perr=%b", i, evq[i].cyc, evq[i].kind, evq[i].data, evq[i].perr, exp[i].cyc, exp[i].kind, exp[i].data, exp[i].perr); end
        end
    endtask

    task automatic test_pulse_rules();
        checks++;
        if (rule_viol !== 0) begin failures++; $display("FAIL pulse_rules: got %0d violations want 0", rule_viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err_break();
        test_overrun();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_pulse_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
